// File: rtl/game_button_checker.sv
// Button side of the LEDs-vs-buttons game: synchronizes and debounces four buttons,
// judges the first press against the LED pattern and keeps the round/hit counters.
module game_button_checker #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       osc_clk,
    input  logic       reset_n,
    input  logic [3:0] btn,
    input  logic [3:0] pattern,
    input  logic       pattern_valid,
    output logic [3:0] btn_stable,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic       miss,
    output logic       timeout,
    output logic [3:0] correct_count,
    output logic [3:0] round_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TM_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CLEAR,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_REPORT
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      cand_q, cand_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [3:0]      btn_stable_q, btn_stable_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic [3:0]      expected_q, expected_d;
    logic            res_hit_q, res_hit_d;
    logic            res_timeout_q, res_timeout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            hit_q, hit_d;
    logic            miss_q, miss_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      correct_count_q, correct_count_d;
    logic [3:0]      round_count_q, round_count_d;

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch can be inferred.
        state_d         = state_q;
        sync1_d         = btn;
        sync2_d         = sync1_q;
        cand_d          = sync2_q;
        db_cnt_d        = db_cnt_q;
        btn_stable_d    = btn_stable_q;
        timer_d         = timer_q;
        expected_d      = expected_q;
        res_hit_d       = res_hit_q;
        res_timeout_d   = res_timeout_q;
        correct_count_d = correct_count_q;
        round_count_d   = round_count_q;

        // Accept a new vector only after it has been unchanged for DEBOUNCE_CYCLES samples.
        if (sync2_q != cand_q || sync2_q == btn_stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_stable_d = cand_q;
            db_cnt_d     = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pattern_valid) begin
                    expected_d = pattern;
                    timer_d    = '0;
                    state_d    = (btn_stable_q == 4'b0000) ? S_WAIT_PRESS : S_WAIT_CLEAR;
                end
            end
            S_WAIT_CLEAR: begin
                if (btn_stable_q == 4'b0000) begin
                    timer_d = '0;
                    state_d = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                timer_d = timer_q + 1'b1;
                if (btn_stable_q != 4'b0000) begin
                    res_hit_d     = (btn_stable_q == expected_q);
                    res_timeout_d = 1'b0;
                    state_d       = S_WAIT_RELEASE;
                end else if (timer_q == TM_LAST) begin
                    res_hit_d     = 1'b0;
                    res_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end
            end
            S_WAIT_RELEASE: begin
                if (btn_stable_q == 4'b0000) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Result outputs are registered copies of the state being entered.
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_REPORT);
        hit_d     = done_d && res_hit_d;
        miss_d    = done_d && !res_hit_d;
        timeout_d = done_d && res_timeout_d;

        if (done_d) begin
            round_count_d = round_count_q + 1'b1;
            if (!res_hit_d) begin
                correct_count_d = '0;
            end else if (correct_count_q != 4'hF) begin
                correct_count_d = correct_count_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge osc_clk) begin
        if (reset_n) begin
            state_q         <= S_IDLE;
            sync1_q         <= '0;
            sync2_q         <= '0;
            cand_q          <= '0;
            db_cnt_q        <= '0;
            btn_stable_q    <= '0;
            timer_q         <= '0;
            expected_q      <= '0;
            res_hit_q       <= 1'b0;
            res_timeout_q   <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            hit_q           <= 1'b0;
            miss_q          <= 1'b0;
            timeout_q       <= 1'b0;
            correct_count_q <= '0;
            round_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            cand_q          <= cand_d;
            db_cnt_q        <= db_cnt_d;
            btn_stable_q    <= btn_stable_d;
            timer_q         <= timer_d;
            expected_q      <= expected_d;
            res_hit_q       <= res_hit_d;
            res_timeout_q   <= res_timeout_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            hit_q           <= hit_d;
            miss_q          <= miss_d;
            timeout_q       <= timeout_d;
            correct_count_q <= correct_count_d;
            round_count_q   <= round_count_d;
        end
    end

    assign btn_stable    = btn_stable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign hit           = hit_q;
    assign miss          = miss_q;
    assign timeout       = timeout_q;
    assign correct_count = correct_count_q;
    assign round_count   = round_count_q;

endmodule

// File: tb/tb_game_button_checker.sv
// Directed bench for game_button_checker with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_game_button_checker;

    localparam int DB  = 4;
    localparam int TMO = 32;
    localparam int DB_LAT = DB + 3;

    logic       osc_clk = 1'b0;
    logic       reset_n;
    logic [3:0] btn;
    logic [3:0] pattern;
    logic       pattern_valid;
    logic [3:0] btn_stable;
    logic       busy, done, hit, miss, timeout;
    logic [3:0] correct_count, round_count;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_round   = 4'd0;
    logic [3:0] exp_correct = 4'd0;

    game_button_checker #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .osc_clk      (osc_clk),
        .reset_n      (reset_n),
        .btn          (btn),
        .pattern      (pattern),
        .pattern_valid(pattern_valid),
        .btn_stable   (btn_stable),
        .busy         (busy),
        .done         (done),
        .hit          (hit),
        .miss         (miss),
        .timeout      (timeout),
        .correct_count(correct_count),
        .round_count  (round_count)
    );

    always #5 osc_clk = ~osc_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Strobe pattern_valid for one cycle from IDLE; busy must be up one edge later.
    task automatic strobe(input logic [3:0] pat);
        @(negedge osc_clk);
        pattern       = pat;
        pattern_valid = 1'b1;
        @(negedge osc_clk);
        pattern_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL strobe_busy: busy=%b expected 1", busy);
        end
    endtask

    // Press val for hold cycles, release, and check the single REPORT cycle.
    task automatic press_release(input logic [3:0] val, input int hold, input logic exp_hit);
        btn = val;
        repeat (hold) @(negedge osc_clk);
        checks++;
        if (btn_stable !== val) begin
            errors++;
            $display("FAIL press_stable: btn_stable=%b expected %b", btn_stable, val);
        end
        btn = 4'b0000;
        for (int i = 1; i <= DB_LAT; i++) begin
            @(negedge osc_clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL early_done: done=%b expected 0 at release edge %0d", done, i);
            end
        end
        @(negedge osc_clk);
        exp_round   = exp_round + 4'd1;
        exp_correct = exp_hit ? ((exp_correct == 4'd15) ? 4'd15 : exp_correct + 4'd1) : 4'd0;
        checks++;
        if ({done, hit, miss, timeout} !== {1'b1, exp_hit, !exp_hit, 1'b0}) begin
            errors++;
            $display("FAIL report_flags: done/hit/miss/timeout=%b%b%b%b expected 1%b%b0",
                     done, hit, miss, timeout, exp_hit, !exp_hit);
        end
        checks++;
        if (correct_count !== exp_correct || round_count !== exp_round) begin
            errors++;
            $display("FAIL counters: correct=%0d round=%0d expected correct=%0d round=%0d",
                     correct_count, round_count, exp_correct, exp_round);
        end
        @(negedge osc_clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL report_end: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset;
        reset_n       = 1'b1;
        btn           = 4'b1111;
        pattern       = 4'b0001;
        pattern_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge osc_clk);
            checks++;
            if ({btn_stable, busy, done, hit, miss, timeout, correct_count, round_count} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs: stable=%b busy=%b done=%b hit=%b miss=%b to=%b cc=%0d rc=%0d expected all 0",
                         btn_stable, busy, done, hit, miss, timeout, correct_count, round_count);
            end
            pattern_valid = ~pattern_valid;
        end
        reset_n       = 1'b0;
        pattern_valid = 1'b0;
        for (int i = 1; i < DB_LAT; i++) begin
            @(negedge osc_clk);
            checks++;
            if (btn_stable !== 4'b0000) begin
                errors++;
                $display("FAIL debounce_early: btn_stable=%b expected 0000 at edge %0d", btn_stable, i);
            end
        end
        @(negedge osc_clk);
        checks++;
        if (btn_stable !== 4'b1111 || busy !== 1'b0) begin
            errors++;
            $display("FAIL debounce_latency: btn_stable=%b busy=%b expected 1111 0", btn_stable, busy);
        end
        btn = 4'b0000;
        repeat (DB_LAT) @(negedge osc_clk);
        checks++;
        if (btn_stable !== 4'b0000) begin
            errors++;
            $display("FAIL debounce_release: btn_stable=%b expected 0000", btn_stable);
        end
    endtask

    task automatic test_hit;
        strobe(4'b0100);
        press_release(4'b0100, 20, 1'b1);
        strobe(4'b0010);
        press_release(4'b0010, 10, 1'b1);
        strobe(4'b0010);
        press_release(4'b0010, 10, 1'b1);
    endtask

    task automatic test_glitch_wrong_press;
        strobe(4'b0010);
        btn = 4'b0001;
        repeat (2) @(negedge osc_clk);
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge osc_clk);
            checks++;
            if (btn_stable !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL glitch: btn_stable=%b busy=%b done=%b expected 0000 1 0", btn_stable, busy, done);
            end
        end
        press_release(4'b0011, 10, 1'b0);
    endtask

    task automatic test_timeout;
        strobe(4'b0001);
        for (int i = 1; i < TMO; i++) begin
            @(negedge osc_clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early: done=%b busy=%b expected 0 1 at cycle %0d", done, busy, i);
            end
            if (i == 10) begin
                pattern       = 4'b0001;
                pattern_valid = 1'b1;
            end
            if (i == 11) pattern_valid = 1'b0;
        end
        @(negedge osc_clk);
        exp_round   = exp_round + 4'd1;
        exp_correct = 4'd0;
        checks++;
        if ({done, hit, miss, timeout} !== 4'b1011) begin
            errors++;
            $display("FAIL timeout_flags: done/hit/miss/timeout=%b%b%b%b expected 1011", done, hit, miss, timeout);
        end
        checks++;
        if (round_count !== exp_round || correct_count !== exp_correct) begin
            errors++;
            $display("FAIL timeout_counters: correct=%0d round=%0d expected correct=%0d round=%0d",
                     correct_count, round_count, exp_correct, exp_round);
        end
        pattern_valid = 1'b1;
        @(negedge osc_clk);
        pattern_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_end: done=%b busy=%b expected 0 0", done, busy);
        end
        @(negedge osc_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL report_strobe_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_held_button;
        btn = 4'b1000;
        repeat (DB_LAT) @(negedge osc_clk);
        checks++;
        if (btn_stable !== 4'b1000) begin
            errors++;
            $display("FAIL held_stable: btn_stable=%b expected 1000", btn_stable);
        end
        strobe(4'b1000);
        for (int i = 0; i < 40; i++) begin
            @(negedge osc_clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_clear: done=%b busy=%b expected 0 1 at cycle %0d", done, busy, i);
            end
        end
        btn = 4'b0000;
        repeat (DB_LAT) @(negedge osc_clk);
        checks++;
        if (btn_stable !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_release: btn_stable=%b busy=%b done=%b expected 0000 1 0", btn_stable, busy, done);
        end
        press_release(4'b1000, 10, 1'b1);
    endtask

    task automatic test_saturation_wrap;
        @(negedge osc_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge osc_clk);
        reset_n     = 1'b0;
        exp_round   = 4'd0;
        exp_correct = 4'd0;
        for (int i = 0; i < 17; i++) begin
            strobe(4'b0001 << (i % 4));
            press_release(4'b0001 << (i % 4), 8, 1'b1);
        end
        checks++;
        if (correct_count !== 4'd15 || round_count !== 4'd1) begin
            errors++;
            $display("FAIL saturate_wrap: correct=%0d round=%0d expected 15 1", correct_count, round_count);
        end
    endtask

    task automatic test_reset_mid_release;
        strobe(4'b0100);
        btn = 4'b0100;
        repeat (DB_LAT + 2) @(negedge osc_clk);
        checks++;
        if (btn_stable !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_release_setup: btn_stable=%b busy=%b expected 0100 1", btn_stable, busy);
        end
        reset_n = 1'b1;
        @(negedge osc_clk);
        exp_round   = 4'd0;
        exp_correct = 4'd0;
        checks++;
        if ({btn_stable, busy, done, correct_count, round_count} !== {4'b0, 1'b0, 1'b0, exp_correct, exp_round}) begin
            errors++;
            $display("FAIL mid_reset: stable=%b busy=%b done=%b cc=%0d rc=%0d expected 0000 0 0 0 0",
                     btn_stable, busy, done, correct_count, round_count);
        end
        btn = 4'b0000;
        @(negedge osc_clk);
        reset_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge osc_clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || round_count !== exp_round) begin
                errors++;
                $display("FAIL after_reset: done=%b busy=%b round=%0d expected 0 0 0", done, busy, round_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_glitch_wrong_press();
        test_timeout();
        test_held_button();
        test_saturation_wrap();
        test_reset_mid_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
